mem_bridge: RTL

- Memory-side bridge directly downstream of the CPU core's memory port.
- Consumes the core's read/write/instruction-access strobes, address and write data.
- Runs single-word or two-word transactions on a req/ack external memory port.
- Returns data and the busy/ready/command-ack handshake the core and its fetch unit expect, plus a sticky timeout error.

---
 rtl/mem_bridge.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: bridge between the CPU core memory port and a req/ack memory.
// A core read/write strobe seen in IDLE is latched and turned into one memory
// transaction. An instruction read is two halfword transactions. Results
// return to the core together with the busy/ready/cack handshake. Unacked
// requests are aborted after TIMEOUT cycles and set a sticky error flag.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cpu_addr/wdata     word address and write data from the core
//   cpu_read/write     request levels (write wins when both are high)
//   cpu_instr          access targets instruction space
//   cpu_read_done      core has consumed read data (releases HOLD)
//   cpu_rdata          data-space read result
//   cpu_instr_data     32-bit instruction read result
//   cpu_busy/ready     transaction in progress / result valid
//   cpu_cack           one-cycle command-accepted pulse
//   bus_err            sticky timeout flag
//   mem_*              halfword-addressed req/ack memory port
module mem_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic        cpu_instr,
  input  logic        cpu_read_done,
  output logic [15:0] cpu_rdata,
  output logic [31:0] cpu_instr_data,
  output logic        cpu_busy,
  output logic        cpu_ready,
  output logic        cpu_cack,
  output logic        bus_err,
  output logic [17:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, HOLD, WR, WR_END} state_t;

  // Counter value on the last cycle a request may stay unacknowledged.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  logic [15:0]      addr_q;
  logic             instr_q;
  logic [CNT_W-1:0] cnt;

  logic        timeout_hit;
  logic        finish;
  logic [15:0] rd_word;

  // An ack in the same cycle as the timeout wins: data is used, no error.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign finish      = mem_req && (mem_ack || timeout_hit);
  assign rd_word     = mem_ack ? mem_rdata : 16'hFFFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      instr_q        <= 1'b0;
      cnt            <= '0;
      cpu_rdata      <= '0;
      cpu_instr_data <= '0;
      cpu_busy       <= 1'b0;
      cpu_ready      <= 1'b0;
      cpu_cack       <= 1'b0;
      bus_err        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
    end else begin
      cpu_cack <= 1'b0;
      if (finish && !mem_ack) bus_err <= 1'b1;

      case (state)
        IDLE: begin
          if (cpu_write || cpu_read) begin
            addr_q   <= cpu_addr;
            instr_q  <= cpu_instr;
            cpu_cack <= 1'b1;
            cpu_busy <= 1'b1;
            mem_req  <= 1'b1;
            cnt      <= '0;
            if (cpu_write) begin
              mem_we    <= 1'b1;
              mem_wdata <= cpu_wdata;
              // Instruction writes are halfword-addressed in the low half of
              // instruction space.
              mem_addr  <= cpu_instr ? {2'b10, cpu_addr} : {2'b00, cpu_addr};
              state     <= WR;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= cpu_instr ? {1'b1, cpu_addr, 1'b0} : {2'b00, cpu_addr};
              state    <= RD_LO;
            end
          end
        end

        WR: begin
          if (finish) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_busy  <= 1'b0;
            cpu_ready <= 1'b1;
            state     <= WR_END;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WR_END: begin
          cpu_ready <= 1'b0;
          state     <= IDLE;
        end

        RD_LO: begin
          if (finish) begin
            mem_req <= 1'b0;
            if (instr_q) begin
              cpu_instr_data[15:0] <= rd_word;
              mem_addr             <= {1'b1, addr_q, 1'b1};
              state                <= RD_HI;
            end else begin
              cpu_rdata <= rd_word;
              cpu_busy  <= 1'b0;
              cpu_ready <= 1'b1;
              state     <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RD_HI: begin
          // Entered with mem_req low, giving the one-cycle gap between halves.
          if (!mem_req) begin
            mem_req <= 1'b1;
            cnt     <= '0;
          end else if (finish) begin
            mem_req               <= 1'b0;
            cpu_instr_data[31:16] <= rd_word;
            cpu_busy              <= 1'b0;
            cpu_ready             <= 1'b1;
            state                 <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (cpu_read_done) begin
            cpu_ready <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
